ild1420_axil_regs: RTL and testbench
====================================

ILD1420_AXIL_REGS -- requirements
Module: ild1420_axil_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, 5, byte-address width; decode uses bits [4:2].
REQ-003 Port S_AXI_ACLK, in, 1: the single clock. Every flop SHALL be clocked on its rising edge.
REQ-004 Port S_AXI_ARESET, in, 1: reset, synchronous and active-high.
REQ-005 Write-address ports: S_AXI_AWADDR in 5; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-006 Write-data ports: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-007 Write-response ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-008 Read-address ports: S_AXI_ARADDR in 5; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-009 Read-data ports: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-010 Port dist_data, in, 16: distance sample from the sensor UART decoder.
REQ-011 Port dist_valid, in, 1: one-cycle strobe qualifying dist_data.
REQ-012 Ports ctrl_reg, cfg_reg, user_reg0, user_reg1, out, 32 each: registers 0x00, 0x04, 0x08 and 0x0C.

Function
REQ-013 Register map: 0x00-0x0C are read/write; 0x10 DIST is read-only, {16'h0, last sample}; 0x14 COUNT is read-only, a 32-bit count of samples.
REQ-014 Addresses 0x18 and 0x1C SHALL read 0, and writes to them are ignored; writes to 0x10 and 0x14 are also ignored.
REQ-015 BRESP and RRESP SHALL always be OKAY (2'b00).
REQ-016 The write path is a state machine: W_IDLE -> W_RESP -> W_IDLE.
REQ-017 In W_IDLE, AWREADY and WREADY SHALL each be asserted only when both AWVALID and WVALID are high, so both channels complete in the same cycle.
REQ-018 On the write handshake, the register update occurs on that edge and the FSM enters W_RESP with BVALID=1 from the next cycle.
REQ-019 In W_RESP, BVALID SHALL be held until BREADY; AWREADY and WREADY stay 0; the FSM returns to W_IDLE on the BVALID&&BREADY edge.
REQ-020 Write throughput is at most one write per 2 cycles.
REQ-021 Writes are byte-enabled: for each set WSTRB[i], byte i is updated; WSTRB=0 SHALL complete with OKAY and change nothing.
REQ-022 The read path is a state machine: R_IDLE -> R_DATA -> R_IDLE.
REQ-023 In R_IDLE, ARREADY SHALL be 1; on the ARVALID handshake, RDATA is registered and RVALID=1 on the next cycle.
REQ-024 In R_DATA, RDATA and RVALID SHALL be held stable until RREADY; ARREADY stays 0.
REQ-025 Read latency is 1 cycle from the AR handshake to RVALID.
REQ-026 The read and write FSMs are independent; a simultaneous read and write to the same address SHALL return the pre-write value.
REQ-027 On dist_valid, DIST is loaded and COUNT increments modulo 2^32 (0xFFFFFFFF -> 0).
REQ-028 dist_valid coinciding with a read of DIST or COUNT SHALL return the pre-update value.
REQ-029 ctrl_reg, cfg_reg, user_reg0 and user_reg1 are driven directly from their flops (0 cycles after the update edge).

Reset
REQ-030 While S_AXI_ARESET=1 at a clock edge, all registers, DIST and COUNT are cleared to 0.
REQ-031 While S_AXI_ARESET=1, both FSMs go to IDLE and AWREADY, WREADY, BVALID, ARREADY, RVALID and RDATA are all 0.
REQ-032 ARREADY SHALL rise on the first cycle after reset deasserts.
REQ-033 Reset mid-transaction SHALL abandon the transaction; no response is issued afterwards.

Structure
REQ-034 Package ild1420_axil_pkg SHALL hold the register offset constants, the RESP_OKAY constant, and the w_state_t and r_state_t enums.
REQ-035 One sub-module, ild1420_sample_capture, SHALL hold the DIST and COUNT logic; the AXI logic stays in the top module.

Verification
REQ-036 Write 0x1,0x2,0x3,0x4 to 0x00-0x0C, then read back -> 0x1,0x2,0x3,0x4; BRESP and RRESP = 0.
REQ-037 Write 0xAABBCCDD to 0x08, then write 0x11223344 with WSTRB=4'b0101 -> reads 0xAA22CC44; user_reg0 matches.
REQ-038 AWVALID 3 cycles before WVALID, with BREADY held low 4 cycles -> one response only; BVALID stable throughout.
REQ-039 Three dist_valid pulses with 0x1234, 0x0042, 0xFFFF -> DIST = 0x0000FFFF and COUNT = 3; a write to 0x10 leaves DIST unchanged.
REQ-040 Preload COUNT to 0xFFFFFFFF via 2^32-1 strobes (or force in the bench) and pulse once -> COUNT reads 0.
REQ-041 Assert reset while BVALID=1 -> BVALID=0 next edge; registers read 0 after release.

Source files
------------

// File: rtl/ild1420_axil_pkg.sv
// Shared register map, response code and FSM state types for the ILD1420 AXI4-Lite register block.
package ild1420_axil_pkg;

  localparam logic [4:0] ADDR_CTRL  = 5'h00;
  localparam logic [4:0] ADDR_CFG   = 5'h04;
  localparam logic [4:0] ADDR_USER0 = 5'h08;
  localparam logic [4:0] ADDR_USER1 = 5'h0C;
  localparam logic [4:0] ADDR_DIST  = 5'h10;
  localparam logic [4:0] ADDR_COUNT = 5'h14;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Merge only the strobed bytes of a write into an existing register value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ild1420_sample_capture.sv
// Holds the most recent sensor distance sample and a free-running count of accepted samples.
module ild1420_sample_capture
  import ild1420_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dist_data,
  input  logic        dist_valid,
  output logic [15:0] dist_q,
  output logic [31:0] count_q
);

  // The count wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      dist_q  <= '0;
      count_q <= '0;
    end else if (dist_valid) begin
      dist_q  <= dist_data;
      count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: rtl/ild1420_axil_regs.sv
// AXI4-Lite slave exposing four R/W control registers plus read-only DIST and COUNT sample status.
//   state  | meaning
//   W_IDLE | waiting for AW and W together; both accepted in the same cycle
//   W_RESP | write applied, BVALID held until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | registered RDATA/RVALID held until RREADY
module ild1420_axil_regs
  import ild1420_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [15:0]                     dist_data,
  input  logic                            dist_valid,
  output logic [31:0]                     ctrl_reg,
  output logic [31:0]                     cfg_reg,
  output logic [31:0]                     user_reg0,
  output logic [31:0]                     user_reg1
);

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic        w_en;
  logic        ar_hs;
  logic [4:0]  aw_off, ar_off;
  logic [31:0] ctrl_q, cfg_q, user0_q, user1_q;
  logic [31:0] rd_mux, rdata_q;
  logic [15:0] dist_q;
  logic [31:0] count_q;
  logic        unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_off = {S_AXI_AWADDR[4:2], 2'b00};
  assign ar_off = {S_AXI_ARADDR[4:2], 2'b00};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Handshake outputs are forced low while reset is asserted, even before the first reset edge.
  always_comb begin
    w_next        = w_state;
    w_en          = 1'b0;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (!S_AXI_ARESET && S_AXI_AWVALID && S_AXI_WVALID) begin
          S_AXI_AWREADY = 1'b1;
          S_AXI_WREADY  = 1'b1;
          w_en          = 1'b1;
          w_next        = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = !S_AXI_ARESET;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    ar_hs         = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = !S_AXI_ARESET;
        if (!S_AXI_ARESET && S_AXI_ARVALID) begin
          ar_hs  = 1'b1;
          r_next = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = !S_AXI_ARESET;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ctrl_q  <= '0;
      cfg_q   <= '0;
      user0_q <= '0;
      user1_q <= '0;
    end else if (w_en) begin
      case (aw_off)
        ADDR_CTRL:  ctrl_q  <= apply_strb(ctrl_q,  S_AXI_WDATA, S_AXI_WSTRB);
        ADDR_CFG:   cfg_q   <= apply_strb(cfg_q,   S_AXI_WDATA, S_AXI_WSTRB);
        ADDR_USER0: user0_q <= apply_strb(user0_q, S_AXI_WDATA, S_AXI_WSTRB);
        ADDR_USER1: user1_q <= apply_strb(user1_q, S_AXI_WDATA, S_AXI_WSTRB);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ar_off)
      ADDR_CTRL:  rd_mux = ctrl_q;
      ADDR_CFG:   rd_mux = cfg_q;
      ADDR_USER0: rd_mux = user0_q;
      ADDR_USER1: rd_mux = user1_q;
      ADDR_DIST:  rd_mux = {16'h0000, dist_q};
      ADDR_COUNT: rd_mux = count_q;
      default:    rd_mux = '0;
    endcase
  end

  // Captured on the AR handshake edge, so a concurrent write or sample returns the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) rdata_q <= '0;
    else if (ar_hs)   rdata_q <= rd_mux;
  end

  ild1420_sample_capture u_capture (
    .clk        (S_AXI_ACLK),
    .rst        (S_AXI_ARESET),
    .dist_data  (dist_data),
    .dist_valid (dist_valid),
    .dist_q     (dist_q),
    .count_q    (count_q)
  );

  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;
  assign ctrl_reg    = ctrl_q;
  assign cfg_reg     = cfg_q;
  assign user_reg0   = user0_q;
  assign user_reg1   = user1_q;

endmodule

// File: tb/tb_ild1420_axil_regs.sv
// Scoreboard bench for ild1420_axil_regs: drivers queue expected responses, a monitor pops and compares.
module tb_ild1420_axil_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [15:0] dist_data;
  logic        dist_valid;
  logic [31:0] ctrl_reg, cfg_reg, user_reg0, user_reg1;

  int errors = 0;
  int checks = 0;

  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_r_q[$];
  string       exp_n_q[$];
  logic [1:0]  pop_b;
  logic [31:0] pop_r;
  string       pop_n;

  always #5 clk = ~clk;

  ild1420_axil_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .dist_data     (dist_data),
    .dist_valid    (dist_valid),
    .ctrl_reg      (ctrl_reg),
    .cfg_reg       (cfg_reg),
    .user_reg0     (user_reg0),
    .user_reg1     (user_reg1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Monitor: handshakes are seen at the falling edge and complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bresp actual=bvalid required=no_response");
      end else begin
        pop_b = exp_b_q.pop_front();
        chk("bresp", {30'b0, bresp}, {30'b0, pop_b});
      end
    end
    if (!rst && rvalid && rready) begin
      if (exp_r_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdata actual=%h required=no_response", rdata);
      end else begin
        pop_r = exp_r_q.pop_front();
        pop_n = exp_n_q.pop_front();
        chk(pop_n, rdata, pop_r);
        chk({pop_n, "_rresp"}, {30'b0, rresp}, 32'h0);
      end
    end
  end

  task automatic wait_aw();
    int n = 0;
    @(negedge clk);
    while (!(awready && wready)) begin
      n++;
      if (n > 200) begin
        timeout("aw_handshake");
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_b_q.push_back(2'b00);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    wait_aw();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input string name);
    int n = 0;
    exp_r_q.push_back(exp);
    exp_n_q.push_back(name);
    araddr  = a;
    arvalid = 1'b1;
    @(negedge clk);
    while (!arready) begin
      n++;
      if (n > 200) begin
        timeout("ar_handshake");
        arvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      timeout("response_drain");
      exp_b_q.delete();
      exp_r_q.delete();
      exp_n_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] d);
    dist_data  = d;
    dist_valid = 1'b1;
    @(posedge clk);
    #1;
    dist_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    dist_data = '0; dist_valid = 1'b0;
    repeat (3) @(posedge clk);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    chk("rst_awready", {31'b0, awready}, 32'h0);
    chk("rst_wready",  {31'b0, wready},  32'h0);
    chk("rst_arready", {31'b0, arready}, 32'h0);
    chk("rst_bvalid",  {31'b0, bvalid},  32'h0);
    chk("rst_rvalid",  {31'b0, rvalid},  32'h0);
    chk("rst_rdata",   rdata,            32'h0);
    chk("rst_ctrl",    ctrl_reg,         32'h0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_reset", {31'b0, arready}, 32'h1);
    @(posedge clk);
    #1;

    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h2, 4'hF);
    axi_write(5'h08, 32'h3, 4'hF);
    axi_write(5'h0C, 32'h4, 4'hF);
    wait_idle();
    chk("port_ctrl", ctrl_reg, 32'h1);
    chk("port_cfg", cfg_reg, 32'h2);
    chk("port_user0", user_reg0, 32'h3);
    chk("port_user1", user_reg1, 32'h4);
    axi_read(5'h00, 32'h1, "rd_ctrl");
    axi_read(5'h04, 32'h2, "rd_cfg");
    axi_read(5'h08, 32'h3, "rd_user0");
    axi_read(5'h0C, 32'h4, "rd_user1");

    axi_write(5'h00, 32'hFFFF_FFFF, 4'h0);
    axi_write(5'h18, 32'h1234_5678, 4'hF);
    axi_read(5'h00, 32'h1, "rd_ctrl_strb0");
    axi_read(5'h18, 32'h0, "rd_0x18");
    axi_read(5'h1C, 32'h0, "rd_0x1c");

    axi_write(5'h08, 32'hAABB_CCDD, 4'hF);
    axi_write(5'h08, 32'h1122_3344, 4'b0101);
    axi_read(5'h08, 32'hAA22_CC44, "rd_user0_strb");
    wait_idle();
    chk("port_user0_strb", user_reg0, 32'hAA22_CC44);

    fork
      axi_write(5'h04, 32'hCAFE_0002, 4'hF);
      axi_read(5'h04, 32'h2, "rd_cfg_prewrite");
    join
    axi_read(5'h04, 32'hCAFE_0002, "rd_cfg_postwrite");
    wait_idle();

    bready = 1'b0;
    exp_b_q.push_back(2'b00);
    awaddr = 5'h0C; wdata = 32'h5A5A_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("awready_without_w", {31'b0, awready}, 32'h0);
      @(posedge clk);
      #1;
    end
    wvalid = 1'b1;
    wait_aw();
    awvalid = 1'b0;
    wvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bvalid_hold", {31'b0, bvalid}, 32'h1);
      chk("awready_in_resp", {31'b0, awready}, 32'h0);
      @(posedge clk);
      #1;
    end
    bready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    axi_read(5'h0C, 32'h5A5A_0001, "rd_user1_late_w");

    wait_idle();
    pulse(16'h1234);
    pulse(16'h0042);
    pulse(16'hFFFF);
    axi_read(5'h10, 32'h0000_FFFF, "rd_dist");
    axi_read(5'h14, 32'h3, "rd_count");
    axi_write(5'h10, 32'h0000_DEAD, 4'hF);
    axi_write(5'h14, 32'h0000_0099, 4'hF);
    axi_read(5'h10, 32'h0000_FFFF, "rd_dist_after_write");
    wait_idle();
    fork
      axi_read(5'h14, 32'h3, "rd_count_pre_sample");
      pulse(16'hABCD);
    join
    axi_read(5'h14, 32'h4, "rd_count_post_sample");
    axi_read(5'h10, 32'h0000_ABCD, "rd_dist_post_sample");
    wait_idle();

    force dut.u_capture.count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.u_capture.count_q;
    @(posedge clk);
    #1;
    axi_read(5'h14, 32'hFFFF_FFFF, "rd_count_max");
    wait_idle();
    pulse(16'h0007);
    axi_read(5'h14, 32'h0, "rd_count_wrap");
    wait_idle();

    bready = 1'b0;
    axi_write(5'h04, 32'h0000_0077, 4'hF);
    @(negedge clk);
    chk("bvalid_before_reset", {31'b0, bvalid}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("bvalid_after_reset_edge", {31'b0, bvalid}, 32'h0);
    exp_b_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bready = 1'b1;
    @(negedge clk);
    chk("arready_after_reset2", {31'b0, arready}, 32'h1);
    chk("bvalid_after_reset2", {31'b0, bvalid}, 32'h0);
    @(posedge clk);
    #1;
    axi_read(5'h00, 32'h0, "rd_ctrl_reset");
    axi_read(5'h04, 32'h0, "rd_cfg_reset");
    axi_read(5'h08, 32'h0, "rd_user0_reset");
    axi_read(5'h0C, 32'h0, "rd_user1_reset");
    axi_read(5'h10, 32'h0, "rd_dist_reset");
    axi_read(5'h14, 32'h0, "rd_count_reset");
    wait_idle();
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
